alu_seq: RTL

- Parametrised, registered successor to the core 8-bit combinational ALU.
- Opcode set widened (logic, shifts, increment, iterative multiply); result and Z/N/C/V flags are registered.
- Valid/ready handshake lets the control unit stall on multi-cycle MUL.
- Sits between the register file/operand muxes and the writeback/flags path of the CPU core.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 62 ++++++
 rtl/alu_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcode encodings, FSM states
// and bit positions of the packed flag vector.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MOV  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_MOV2 = 4'b1001;
    localparam logic [3:0] OP_INC  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_CMP  = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done/product are combinational on the final iteration so the caller can
// register the result on the same edge the last partial sum is formed.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;
    logic               busy_reg;

    // Partial sum for the current iteration
    always_comb begin
        acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    end

    assign busy    = busy_reg;
    assign done    = busy_reg && (count_reg == CW'(WIDTH - 1));
    assign product = acc_next;

    // Load operands on start, then shift/accumulate until the last count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (start && !busy_reg) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            acc_reg    <= '0;
            mplier_reg <= b;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake. Single-cycle ops complete on
// the accepting edge; MUL (when enabled) stalls the input for WIDTH cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int M = WIDTH - 1;

    state_t             state_reg;
    logic [WIDTH-1:0]   out_reg;
    logic [3:0]         flags_reg;
    logic               out_valid_reg;
    logic               in_ready_reg;

    logic [WIDTH-1:0]   res_next;
    logic [3:0]         flags_next;
    logic [WIDTH:0]     sum_add;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     sum_inc;

    logic               fire;
    logic               is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign fire      = in_valid && in_ready_reg && (state_reg == ST_IDLE);
    assign is_mul    = (s == OP_MUL) && (MUL_EN != 0);
    assign mul_start = fire && is_mul && !mul_busy;

    assign sum_add = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign sum_inc = {1'b0, a} + (WIDTH+1)'(1);

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start),
                .a       (a),
                .b       (b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_busy    = 1'b0;
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    // Single-cycle result and flags; MUL falls to the unassigned case here
    always_comb begin
        res_next   = '0;
        flags_next = '0;
        case (s)
            OP_ADD: begin
                res_next           = sum_add[M:0];
                flags_next[FLAG_C] = sum_add[WIDTH];
                flags_next[FLAG_V] = (a[M] == b[M]) && (sum_add[M] != a[M]);
            end
            OP_SUB, OP_CMP: begin
                res_next           = diff[M:0];
                flags_next[FLAG_C] = diff[WIDTH];
                flags_next[FLAG_V] = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_MOV, OP_MOV2: res_next = b;
            OP_AND:          res_next = a & b;
            OP_OR:           res_next = a | b;
            OP_XOR:          res_next = a ^ b;
            OP_NOT:          res_next = ~a;
            OP_SHL: begin
                res_next           = {a[M-1:0], 1'b0};
                flags_next[FLAG_C] = a[M];
            end
            OP_SHR: begin
                res_next           = {1'b0, a[M:1]};
                flags_next[FLAG_C] = a[0];
            end
            OP_INC: begin
                res_next           = sum_inc[M:0];
                flags_next[FLAG_C] = sum_inc[WIDTH];
                flags_next[FLAG_V] = !a[M] && sum_inc[M];
            end
            default: res_next = '0;
        endcase
        // Z/N come from the subtraction for CMP, which then reports equality
        flags_next[FLAG_Z] = (res_next == '0);
        flags_next[FLAG_N] = res_next[M];
        if (s == OP_CMP) begin
            res_next = (a == b) ? WIDTH'(1) : '0;
        end
    end

    // Handshake FSM with registered result, flags and pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            out_reg       <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (fire) begin
                        if (is_mul) begin
                            state_reg    <= ST_MUL;
                            in_ready_reg <= 1'b0;
                        end else begin
                            out_reg       <= res_next;
                            flags_reg     <= flags_next;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        out_reg            <= mul_product[M:0];
                        flags_reg[FLAG_Z]  <= (mul_product[M:0] == '0);
                        flags_reg[FLAG_N]  <= mul_product[M];
                        flags_reg[FLAG_C]  <= |mul_product[2*WIDTH-1:WIDTH];
                        flags_reg[FLAG_V]  <= 1'b0;
                        out_valid_reg      <= 1'b1;
                        state_reg          <= ST_IDLE;
                        in_ready_reg       <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign flag_z    = flags_reg[FLAG_Z];
    assign flag_n    = flags_reg[FLAG_N];
    assign flag_c    = flags_reg[FLAG_C];
    assign flag_v    = flags_reg[FLAG_V];

endmodule
